// File: rtl/sc_inst_encoder_pkg.sv
// Shared ISA constants for the single-cycle MIPS subset: opcodes, function codes,
// mnemonic numbering and error codes, plus field-packing helpers.
package sc_inst_encoder_pkg;

   typedef enum logic [4:0] {
      MN_ADD  = 5'd0,
      MN_SUB  = 5'd1,
      MN_AND  = 5'd2,
      MN_OR   = 5'd3,
      MN_EVEN = 5'd4,
      MN_XOR  = 5'd5,
      MN_SLL  = 5'd6,
      MN_SRL  = 5'd7,
      MN_SRA  = 5'd8,
      MN_JR   = 5'd9,
      MN_ADDI = 5'd10,
      MN_ANDI = 5'd11,
      MN_ORI  = 5'd12,
      MN_XORI = 5'd13,
      MN_LW   = 5'd14,
      MN_SW   = 5'd15,
      MN_LUI  = 5'd16,
      MN_BEQ  = 5'd17,
      MN_BNE  = 5'd18,
      MN_J    = 5'd19,
      MN_JAL  = 5'd20
   } mnem_e;

   typedef enum logic [1:0] {
      ERR_NONE   = 2'd0,
      ERR_MNEM   = 2'd1,
      ERR_BRANCH = 2'd2,
      ERR_JUMP   = 2'd3
   } err_e;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_XORI  = 6'b001110;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [5:0] FN_SLL   = 6'b000000;
   localparam logic [5:0] FN_SRL   = 6'b000010;
   localparam logic [5:0] FN_SRA   = 6'b000011;
   localparam logic [5:0] FN_JR    = 6'b001000;
   localparam logic [5:0] FN_ADD   = 6'b100000;
   localparam logic [5:0] FN_EVEN  = 6'b100001;
   localparam logic [5:0] FN_SUB   = 6'b100010;
   localparam logic [5:0] FN_AND   = 6'b100100;
   localparam logic [5:0] FN_OR    = 6'b100101;
   localparam logic [5:0] FN_XOR   = 6'b100110;

   // Branch displacement must fit a signed 18-bit byte offset (16-bit word offset).
   localparam logic signed [31:0] BR_MIN = -32'sd131072;
   localparam logic signed [31:0] BR_MAX = 32'sd131071;

   typedef struct packed {
      logic        ok;
      err_e        code;
      logic [31:0] word;
   } enc_t;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] word;
   } entry_t;

   function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] shamt,
                                          input logic [5:0] fn);
      return {OP_RTYPE, rs, rt, rd, shamt, fn};
   endfunction

   function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

endpackage

// File: rtl/sc_inst_encoder_fifo.sv
// Output FIFO for encoded words: DEPTH entries, synchronous flush, async reset on pointers.
// Head data reads as zero whenever the FIFO is empty.
module sc_inst_encoder_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 64
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head_data
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_push = push & ~full & ~flush;
   assign do_pop  = pop & ~empty & ~flush;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage is data only; validity is carried entirely by the pointers.
   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
   end

   assign head_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/sc_inst_encoder.sv
// Symbolic-to-binary encoder for the single-cycle MIPS subset; tracks the byte address of
// each emitted word, resolves branch/jump targets and queues {addr,word} in an output FIFO.
module sc_inst_encoder
   import sc_inst_encoder_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0,
   parameter int          DEPTH     = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        restart,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [4:0]  in_mnem,
   input  logic [4:0]  in_rs,
   input  logic [4:0]  in_rt,
   input  logic [4:0]  in_rd,
   input  logic [4:0]  in_shamt,
   input  logic [15:0] in_imm,
   input  logic [31:0] in_target,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_addr,
   output logic [31:0] out_word,
   output logic        err,
   output logic [1:0]  err_code
);

   logic [31:0] addr_cnt;
   err_e        err_code_q;
   logic        err_q;
   enc_t        enc_p0;
   logic        accept;
   logic        push;
   logic        pop;
   logic        fifo_full;
   logic        fifo_empty;
   entry_t      head;

   function automatic enc_t encode(input logic [4:0]  mnem,
                                   input logic [4:0]  rs,
                                   input logic [4:0]  rt,
                                   input logic [4:0]  rd,
                                   input logic [4:0]  shamt,
                                   input logic [15:0] imm,
                                   input logic [31:0] target,
                                   input logic [31:0] pc);
      enc_t               r;
      logic [31:0]        pc4;
      logic signed [31:0] diff;
      logic               br_ok;
      logic               j_ok;
      r.ok   = 1'b1;
      r.code = ERR_NONE;
      r.word = '0;
      pc4    = pc + 32'd4;
      diff   = $signed(target - pc4);
      br_ok  = (target[1:0] == 2'b00) && (diff >= BR_MIN) && (diff <= BR_MAX);
      j_ok   = (target[1:0] == 2'b00) && (target[31:28] == pc4[31:28]);
      case (mnem_e'(mnem))
         MN_ADD:  r.word = r_word(rs, rt, rd, 5'd0, FN_ADD);
         MN_SUB:  r.word = r_word(rs, rt, rd, 5'd0, FN_SUB);
         MN_AND:  r.word = r_word(rs, rt, rd, 5'd0, FN_AND);
         MN_OR:   r.word = r_word(rs, rt, rd, 5'd0, FN_OR);
         MN_EVEN: r.word = r_word(rs, rt, rd, 5'd0, FN_EVEN);
         MN_XOR:  r.word = r_word(rs, rt, rd, 5'd0, FN_XOR);
         MN_SLL:  r.word = r_word(5'd0, rt, rd, shamt, FN_SLL);
         MN_SRL:  r.word = r_word(5'd0, rt, rd, shamt, FN_SRL);
         MN_SRA:  r.word = r_word(5'd0, rt, rd, shamt, FN_SRA);
         MN_JR:   r.word = r_word(rs, 5'd0, 5'd0, 5'd0, FN_JR);
         MN_ADDI: r.word = i_word(OP_ADDI, rs, rt, imm);
         MN_ANDI: r.word = i_word(OP_ANDI, rs, rt, imm);
         MN_ORI:  r.word = i_word(OP_ORI, rs, rt, imm);
         MN_XORI: r.word = i_word(OP_XORI, rs, rt, imm);
         MN_LW:   r.word = i_word(OP_LW, rs, rt, imm);
         MN_SW:   r.word = i_word(OP_SW, rs, rt, imm);
         MN_LUI:  r.word = i_word(OP_LUI, 5'd0, rt, imm);
         MN_BEQ, MN_BNE: begin
            if (br_ok) begin
               r.word = i_word((mnem_e'(mnem) == MN_BEQ) ? OP_BEQ : OP_BNE, rs, rt, diff[17:2]);
            end else begin
               r.ok   = 1'b0;
               r.code = ERR_BRANCH;
            end
         end
         MN_J, MN_JAL: begin
            if (j_ok) begin
               r.word = {((mnem_e'(mnem) == MN_J) ? OP_J : OP_JAL), target[27:2]};
            end else begin
               r.ok   = 1'b0;
               r.code = ERR_JUMP;
            end
         end
         default: begin
            r.ok   = 1'b0;
            r.code = ERR_MNEM;
         end
      endcase
      return r;
   endfunction

   // Stage p0: handshake and combinational encode against the current address.
   assign in_ready = ~fifo_full & ~restart;
   assign accept   = in_valid & in_ready;
   assign enc_p0   = encode(in_mnem, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target, addr_cnt);
   assign push     = accept & enc_p0.ok;
   assign pop      = ~fifo_empty & out_ready & ~restart;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         addr_cnt   <= BASE_ADDR;
         err_q      <= 1'b0;
         err_code_q <= ERR_NONE;
      end else if (restart) begin
         addr_cnt   <= BASE_ADDR;
         err_q      <= 1'b0;
         err_code_q <= ERR_NONE;
      end else if (accept) begin
         if (enc_p0.ok) begin
            addr_cnt <= addr_cnt + 32'd4;
         end else begin
            err_q <= 1'b1;
            if (!err_q) err_code_q <= enc_p0.code;
         end
      end
   end

   // Stage p1: queued {addr, word} entries.
   sc_inst_encoder_fifo #(
      .DEPTH (DEPTH),
      .WIDTH ($bits(entry_t))
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .flush     (restart),
      .push      (push),
      .push_data ({addr_cnt, enc_p0.word}),
      .pop       (pop),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .head_data (head)
   );

   assign out_valid = ~fifo_empty;
   assign out_addr  = head.addr;
   assign out_word  = head.word;
   assign err       = err_q;
   assign err_code  = err_code_q;

endmodule

// File: tb/tb_sc_inst_encoder.sv
// Bench for sc_inst_encoder: directed ISA examples and corner cases, then randomized
// traffic checked against a queue-based reference model of the encoder.
module tb_sc_inst_encoder;

   localparam int          DEPTH = 4;
   localparam logic [31:0] BASE  = 32'h0;

   // Mnemonic-indexed opcode / function tables straight from the ISA listing.
   localparam int OP_T [21] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                                8, 12, 13, 14, 35, 43, 15, 4, 5, 2, 3};
   localparam int FN_T [21] = '{32, 34, 36, 37, 33, 38, 0, 2, 3, 8,
                                0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

   logic        clock = 1'b0;
   logic        reset;
   logic        restart;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  in_mnem;
   logic [4:0]  in_rs;
   logic [4:0]  in_rt;
   logic [4:0]  in_rd;
   logic [4:0]  in_shamt;
   logic [15:0] in_imm;
   logic [31:0] in_target;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_addr;
   logic [31:0] out_word;
   logic        err;
   logic [1:0]  err_code;

   int n_checks = 0;
   int n_err    = 0;

   logic [63:0] q[$];
   bit   [31:0] m_addr;
   bit          m_err;
   bit   [1:0]  m_code;

   always #5 clock = ~clock;

   sc_inst_encoder #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
      .clock     (clock),
      .reset     (reset),
      .restart   (restart),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_mnem   (in_mnem),
      .in_rs     (in_rs),
      .in_rt     (in_rt),
      .in_rd     (in_rd),
      .in_shamt  (in_shamt),
      .in_imm    (in_imm),
      .in_target (in_target),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_addr  (out_addr),
      .out_word  (out_word),
      .err       (err),
      .err_code  (err_code)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic void model_encode(input int mn, input bit [4:0] rs, input bit [4:0] rt,
                                        input bit [4:0] rd, input bit [4:0] sh,
                                        input bit [15:0] imm, input bit [31:0] tgt,
                                        input bit [31:0] pc, output bit ok,
                                        output bit [1:0] code, output bit [31:0] w);
      bit [31:0] nxt;
      int        d;
      ok   = 1'b1;
      code = 2'd0;
      w    = 32'd0;
      nxt  = pc + 32'd4;
      if (mn > 20) begin
         ok   = 1'b0;
         code = 2'd1;
      end else if (mn <= 5) begin
         w = 32'(rs) * 32'd2097152 + 32'(rt) * 32'd65536 + 32'(rd) * 32'd2048 + 32'(FN_T[mn]);
      end else if (mn <= 8) begin
         w = 32'(rt) * 32'd65536 + 32'(rd) * 32'd2048 + 32'(sh) * 32'd64 + 32'(FN_T[mn]);
      end else if (mn == 9) begin
         w = 32'(rs) * 32'd2097152 + 32'(FN_T[mn]);
      end else if (mn <= 15) begin
         w = 32'(OP_T[mn]) * 32'd67108864 + 32'(rs) * 32'd2097152 + 32'(rt) * 32'd65536 + 32'(imm);
      end else if (mn == 16) begin
         w = 32'(OP_T[mn]) * 32'd67108864 + 32'(rt) * 32'd65536 + 32'(imm);
      end else if (mn <= 18) begin
         d = int'(tgt - nxt);
         if ((tgt % 4) != 0 || d < -131072 || d > 131071) begin
            ok   = 1'b0;
            code = 2'd2;
         end else begin
            w = 32'(OP_T[mn]) * 32'd67108864 + 32'(rs) * 32'd2097152 + 32'(rt) * 32'd65536
                + (32'(d / 4) & 32'h0000FFFF);
         end
      end else begin
         if ((tgt % 4) != 0 || (tgt / 32'h10000000) != (nxt / 32'h10000000)) begin
            ok   = 1'b0;
            code = 2'd3;
         end else begin
            w = 32'(OP_T[mn]) * 32'd67108864 + (tgt % 32'h10000000) / 32'd4;
         end
      end
   endfunction

   task automatic model_clear();
      q.delete();
      m_addr = BASE;
      m_err  = 1'b0;
      m_code = 2'd0;
   endtask

   task automatic check_outputs();
      chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
      chk("out_addr", out_addr, (q.size() != 0) ? q[0][63:32] : 32'h0);
      chk("out_word", out_word, (q.size() != 0) ? q[0][31:0] : 32'h0);
      chk("err", 32'(err), 32'(m_err));
      chk("err_code", 32'(err_code), 32'(m_code));
   endtask

   task automatic set_req(input int mn, input bit [4:0] rs, input bit [4:0] rt,
                          input bit [4:0] rd, input bit [4:0] sh, input bit [15:0] imm,
                          input bit [31:0] tgt);
      in_valid  = 1'b1;
      in_mnem   = 5'(mn);
      in_rs     = rs;
      in_rt     = rt;
      in_rd     = rd;
      in_shamt  = sh;
      in_imm    = imm;
      in_target = tgt;
   endtask

   // One clock: check in_ready before the edge, predict, then compare after the edge.
   task automatic cycle();
      bit        acc;
      bit        pp;
      bit        ok;
      bit [1:0]  code;
      bit [31:0] w;
      bit        rst_now;
      #1;
      chk("in_ready", 32'(in_ready), 32'((q.size() < DEPTH) && !restart));
      rst_now = restart;
      acc     = in_valid && (q.size() < DEPTH) && !restart;
      pp      = out_ready && (q.size() > 0) && !restart;
      model_encode(int'(in_mnem), in_rs, in_rt, in_rd, in_shamt, in_imm, in_target, m_addr,
                   ok, code, w);
      @(posedge clock);
      #1;
      if (rst_now) begin
         model_clear();
      end else begin
         if (pp) void'(q.pop_front());
         if (acc) begin
            if (ok) begin
               q.push_back({m_addr, w});
               m_addr = m_addr + 32'd4;
            end else begin
               if (!m_err) m_code = code;
               m_err = 1'b1;
            end
         end
      end
      check_outputs();
   endtask

   task automatic rand_add();
      set_req(0, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 16'($urandom),
              $urandom);
   endtask

   initial begin
      bit [31:0] tgt;
      int        off;
      int        mn;
      reset     = 1'b1;
      restart   = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      set_req(0, 0, 0, 0, 0, 0, 0);
      in_valid  = 1'b0;
      model_clear();
      #12;
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_out_addr", out_addr, 32'h0);
      chk("rst_out_word", out_word, 32'h0);
      chk("rst_err", 32'(err), 32'h0);
      chk("rst_err_code", 32'(err_code), 32'h0);
      reset = 1'b0;
      @(posedge clock);
      #1;

      // ISA examples with a draining consumer: each new word is at the head one cycle later.
      out_ready = 1'b1;
      set_req(0, 1, 2, 3, 0, 0, 0);            cycle();
      chk("add_addr", out_addr, 32'h0);
      chk("add_word", out_word, 32'h00221820);
      set_req(17, 1, 2, 0, 0, 0, 32'hC);       cycle();
      chk("beq_fwd_word", out_word, 32'h10220001);
      set_req(19, 0, 0, 0, 0, 0, 32'h40);      cycle();
      chk("j_word", out_word, 32'h08000010);
      set_req(16, 0, 5, 0, 0, 16'h1234, 0);    cycle();
      chk("lui_word", out_word, 32'h3C051234);
      set_req(6, 0, 2, 4, 3, 0, 0);            cycle();
      chk("sll_word", out_word, 32'h000220C0);
      in_valid = 1'b0;
      restart  = 1'b1;                         cycle();
      restart  = 1'b0;
      set_req(0, 1, 2, 3, 0, 0, 0);            cycle();
      set_req(17, 1, 2, 0, 0, 0, 32'h0);       cycle();
      chk("beq_back_addr", out_addr, 32'h4);
      chk("beq_back_word", out_word, 32'h1022FFFE);
      in_valid = 1'b0;                         cycle();

      // Fill to capacity with the consumer stalled; the fifth request must wait.
      out_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         rand_add();
         cycle();
      end
      rand_add();
      #1;
      chk("full_in_ready", 32'(in_ready), 32'h0);
      cycle();
      out_ready = 1'b1;                        cycle();
      out_ready = 1'b0;
      chk("ready_after_pop", 32'(in_ready), 32'h1);
      cycle();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < DEPTH + 1; i++) cycle();

      // Rejected requests: first error code is sticky, address does not advance.
      set_req(25, 1, 2, 3, 0, 0, 0);           cycle();
      chk("badmnem_err", 32'(err), 32'h1);
      chk("badmnem_code", 32'(err_code), 32'h1);
      chk("badmnem_nopush", 32'(out_valid), 32'h0);
      set_req(17, 1, 2, 0, 0, 0, m_addr + 32'd9); cycle();
      chk("sticky_code", 32'(err_code), 32'h1);
      set_req(1, 4, 5, 6, 0, 0, 0);            cycle();
      in_valid = 1'b0;                         cycle();

      // Asynchronous reset landing between clock edges.
      out_ready = 1'b0;
      rand_add();                              cycle();
      rand_add();                              cycle();
      in_valid = 1'b0;
      #3;
      reset = 1'b1;
      #1;
      chk("arst_out_valid", 32'(out_valid), 32'h0);
      chk("arst_out_addr", out_addr, 32'h0);
      chk("arst_out_word", out_word, 32'h0);
      chk("arst_err", 32'(err), 32'h0);
      chk("arst_err_code", 32'(err_code), 32'h0);
      #1;
      reset = 1'b0;
      model_clear();
      @(posedge clock);
      #1;

      // Restart with a queue and a pending request.
      set_req(30, 0, 0, 0, 0, 0, 0);           cycle();
      for (int i = 0; i < 3; i++) begin
         rand_add();
         cycle();
      end
      rand_add();
      restart = 1'b1;                          cycle();
      restart = 1'b0;
      chk("restart_valid", 32'(out_valid), 32'h0);
      chk("restart_err", 32'(err), 32'h0);
      rand_add();                              cycle();
      chk("restart_addr", out_addr, BASE);
      in_valid = 1'b0;

      // Randomized traffic.
      for (int i = 0; i < 600; i++) begin
         mn  = int'($urandom_range(0, 23));
         off = int'($urandom_range(0, 524288)) - 262144;
         if ($urandom_range(0, 7) != 0) off = off & ~3;
         case ($urandom_range(0, 3))
            0:       tgt = $urandom;
            1:       tgt = {m_addr[31:28] + 4'($urandom_range(0, 1)), 26'($urandom), 2'b00};
            default: tgt = m_addr + 32'd4 + 32'(off);
         endcase
         set_req(mn, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 16'($urandom), tgt);
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         restart   = ($urandom_range(0, 59) == 0);
         cycle();
      end
      restart   = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < DEPTH + 1; i++) cycle();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
